// File: rtl/rallyx_video_pkg.sv
// rallyx_video_pkg: shared video widths, default 31 kHz line timing and the pixel type.
// Revision: 1.0
`default_nettype none

package rallyx_video_pkg;

  localparam int RGB_W        = 12;
  localparam int CH_W         = 4;
  localparam int HTOTAL_DEF   = 394;
  localparam int HS_START_DEF = 298;
  localparam int HS_LEN_DEF   = 24;
  localparam int OX_W         = 9;

  typedef logic [RGB_W-1:0] rgb_t;

  // Halve every channel independently so no bit leaks into the channel below.
  function automatic rgb_t rgb_half(input rgb_t c);
    rgb_t r;
    r = '0;
    for (int i = 0; i < RGB_W / CH_W; i++) begin
      r[i*CH_W +: CH_W] = c[i*CH_W +: CH_W] >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rallyx_scandbl_if.sv
// rallyx_scandbl_if: 15 kHz timing-generator inputs and 31 kHz video outputs of the scan doubler.
// Revision: 1.0
`default_nettype none

interface rallyx_scandbl_if;
  import rallyx_video_pkg::*;

  logic PCE;
  rgb_t iRGB;
  logic HBLK;
  logic VBLK;
  logic HSYN;
  logic VSYN;
  rgb_t oRGB;
  logic oHSYN;
  logic oVSYN;
  logic oBLK;

  modport master (
    output PCE, iRGB, HBLK, VBLK, HSYN, VSYN,
    input  oRGB, oHSYN, oVSYN, oBLK
  );

  modport slave (
    input  PCE, iRGB, HBLK, VBLK, HSYN, VSYN,
    output oRGB, oHSYN, oVSYN, oBLK
  );

endinterface

`default_nettype wire

// File: rtl/rallyx_linebuf.sv
// rallyx_linebuf: two line banks in one simple dual-port RAM; bank select is the address MSB.
// Revision: 1.0
`default_nettype none

module rallyx_linebuf
  import rallyx_video_pkg::*;
#(
  parameter int BUF_AW = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [BUF_AW-1:0] waddr,
  input  rgb_t              wdata,
  input  logic              rbank,
  input  logic [BUF_AW-1:0] raddr,
  output rgb_t              rdata
);

  localparam int DEPTH = 2 ** (BUF_AW + 1);

  rgb_t mem [DEPTH];
  rgb_t rdata_q;

  // Contents are deliberately never cleared; the reader blanks until a line is captured.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wbank, waddr}] <= wdata;
    end
    rdata_q <= mem[{rbank, raddr}];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/rallyx_scandbl.sv
// rallyx_scandbl: captures 15 kHz lines and replays each twice at 31 kHz with regenerated hsync.
// Optional: RALLYX_SCANDBL_SCANLINES_EN halves every channel on the second line of each pair.
// Revision: 1.0
`default_nettype none

module rallyx_scandbl
  import rallyx_video_pkg::*;
#(
  parameter int HTOTAL   = HTOTAL_DEF,
  parameter int HS_START = HS_START_DEF,
  parameter int HS_LEN   = HS_LEN_DEF,
  parameter int BUF_AW   = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  rallyx_scandbl_if.slave  vid
);

  localparam int                LEN_W    = BUF_AW + 1;
  localparam logic [LEN_W-1:0]  BANK_PIX = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [OX_W-1:0]   OX_LAST  = OX_W'(HTOTAL - 1);

  logic             hs_d_q,   hs_d_d;
  logic [LEN_W-1:0] wx_q,     wx_d;
  logic [LEN_W-1:0] len_q,    len_d;
  logic             wbank_q,  wbank_d;
  logic             rbank_q,  rbank_d;
  logic             vblk_l_q, vblk_l_d;
  logic             vsyn_l_q, vsyn_l_d;
  logic [OX_W-1:0]  ox_q,     ox_d;
  logic             odd_q,    odd_d;

  logic             blank_p1_q, blank_p1_d;
  logic             hs_p1_q,    hs_p1_d;
  logic             vs_p1_q,    vs_p1_d;

  rgb_t             orgb_q,  orgb_d;
  logic             ohsyn_q, ohsyn_d;
  logic             ovsyn_q, ovsyn_d;
  logic             oblk_q,  oblk_d;

  logic             swap;
  logic             wr_en;
  rgb_t             rdata;
  rgb_t             pix;

  // Falling HSYN seen on a pixel enable starts a new line; it outranks a pixel write.
  assign swap  = vid.PCE & hs_d_q & ~vid.HSYN;
  assign wr_en = vid.PCE & ~vid.HBLK & (wx_q < BANK_PIX) & ~swap;

  rallyx_linebuf #(
    .BUF_AW (BUF_AW)
  ) u_linebuf (
    .clk   (CLK),
    .we    (wr_en),
    .wbank (wbank_q),
    .waddr (wx_q[BUF_AW-1:0]),
    .wdata (vid.iRGB),
    .rbank (rbank_q),
    .raddr (BUF_AW'(ox_q)),
    .rdata (rdata)
  );

  always_comb begin
    hs_d_d   = hs_d_q;
    wx_d     = wx_q;
    len_d    = len_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    vblk_l_d = vblk_l_q;
    vsyn_l_d = vsyn_l_q;
    ox_d     = ox_q + OX_W'(1);
    odd_d    = odd_q;
    if (vid.PCE) begin
      hs_d_d = vid.HSYN;
    end
    if (swap) begin
      len_d    = wx_q;
      wx_d     = '0;
      wbank_d  = ~wbank_q;
      rbank_d  = wbank_q;
      vblk_l_d = vid.VBLK;
      vsyn_l_d = vid.VSYN;
      ox_d     = '0;
      odd_d    = 1'b0;
    end else begin
      if (wr_en) begin
        wx_d = wx_q + LEN_W'(1);
      end
      // Without a new input line the last one keeps repeating as the second of a pair.
      if (ox_q == OX_LAST) begin
        ox_d  = '0;
        odd_d = 1'b1;
      end
    end
  end

  always_comb begin
    blank_p1_d = (32'(ox_q) >= 32'(len_q)) || vblk_l_q;
    hs_p1_d    = !((32'(ox_q) >= HS_START) && (32'(ox_q) < HS_START + HS_LEN));
    vs_p1_d    = vsyn_l_q;
    orgb_d     = blank_p1_q ? '0 : pix;
    oblk_d     = blank_p1_q;
    ohsyn_d    = hs_p1_q;
    ovsyn_d    = vs_p1_q;
  end

`ifdef RALLYX_SCANDBL_SCANLINES_EN
  logic odd_p1_q, odd_p1_d;

  assign odd_p1_d = odd_q;
  assign pix      = odd_p1_q ? rgb_half(rdata) : rdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      odd_p1_q <= 1'b0;
    end else begin
      odd_p1_q <= odd_p1_d;
    end
  end
`else
  assign pix = rdata;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hs_d_q     <= 1'b1;
      wx_q       <= '0;
      len_q      <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      vblk_l_q   <= 1'b1;
      vsyn_l_q   <= 1'b1;
      ox_q       <= '0;
      odd_q      <= 1'b0;
      blank_p1_q <= 1'b1;
      hs_p1_q    <= 1'b1;
      vs_p1_q    <= 1'b1;
      orgb_q     <= '0;
      ohsyn_q    <= 1'b1;
      ovsyn_q    <= 1'b1;
      oblk_q     <= 1'b1;
    end else begin
      hs_d_q     <= hs_d_d;
      wx_q       <= wx_d;
      len_q      <= len_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      vblk_l_q   <= vblk_l_d;
      vsyn_l_q   <= vsyn_l_d;
      ox_q       <= ox_d;
      odd_q      <= odd_d;
      blank_p1_q <= blank_p1_d;
      hs_p1_q    <= hs_p1_d;
      vs_p1_q    <= vs_p1_d;
      orgb_q     <= orgb_d;
      ohsyn_q    <= ohsyn_d;
      ovsyn_q    <= ovsyn_d;
      oblk_q     <= oblk_d;
    end
  end

  assign vid.oRGB  = orgb_q;
  assign vid.oHSYN = ohsyn_q;
  assign vid.oVSYN = ovsyn_q;
  assign vid.oBLK  = oblk_q;

endmodule

`default_nettype wire

// File: tb/tb_rallyx_scandbl.sv
// tb_rallyx_scandbl: directed line sequences for the scan doubler, outputs captured per CLK and checked.
// Revision: 1.0
`default_nettype none

module tb_rallyx_scandbl;
  import rallyx_video_pkg::*;

  localparam int CAP_N = 16384;
  localparam int HT    = 394;

  logic CLK = 1'b0;
  logic RESET;

  rallyx_scandbl_if vid();

  rallyx_scandbl #(
    .HTOTAL   (HT),
    .HS_START (298),
    .HS_LEN   (24),
    .BUF_AW   (9)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .vid   (vid)
  );

  always #5 CLK = ~CLK;

  logic [11:0] cap_rgb [CAP_N];
  logic        cap_blk [CAP_N];
  logic        cap_hs  [CAP_N];
  logic        cap_vs  [CAP_N];

  int tick   = 0;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic step(input logic pce);
    vid.PCE = pce;
    @(posedge CLK);
    #1;
    tick++;
    if (tick < CAP_N) begin
      cap_rgb[tick] = vid.oRGB;
      cap_blk[tick] = vid.oBLK;
      cap_hs[tick]  = vid.oHSYN;
      cap_vs[tick]  = vid.oVSYN;
    end
  endtask

  task automatic idle(input int npix);
    vid.HBLK = 1'b1;
    vid.HSYN = 1'b1;
    vid.iRGB = '0;
    for (int p = 0; p < npix; p++) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  // mode 0: pixel = index, 1: white, 2: 0xA00 + index; HSYN low for 32 pixels from hs_at.
  task automatic drive_line(input int npix, input int active, input int hs_at, input int mode,
                            input logic vb, input logic vs, output int sw);
    sw = 0;
    for (int p = 0; p < npix; p++) begin
      vid.HBLK = (p >= active);
      vid.HSYN = !((p >= hs_at) && (p < hs_at + 32));
      vid.iRGB = (mode == 1) ? 12'hFFF : ((mode == 2) ? 12'hA00 + 12'(p) : 12'(p));
      vid.VBLK = vb;
      vid.VSYN = vs;
      step(1'b1);
      if (p == hs_at) sw = tick;
      step(1'b0);
    end
  endtask

  function automatic logic [15:0] pix(input int t);
    return {3'b000, cap_blk[t], cap_rgb[t]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Output for counter value ox of half h of the pair started at swap tick s.
  function automatic int at(input int s, input int h, input int ox);
    return s + 2 + h * HT + ox;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12;
    int t;

    RESET    = 1'b1;
    vid.PCE  = 1'b0;
    vid.iRGB = '0;
    vid.HBLK = 1'b1;
    vid.VBLK = 1'b0;
    vid.HSYN = 1'b1;
    vid.VSYN = 1'b1;
    for (int i = 0; i < 4; i++) step(i[0] == 1'b0);
    chk("reset_pix", pix(tick), 16'h1000);
    chk("reset_hs", {15'b0, cap_hs[tick]}, 16'h0001);
    chk("reset_vs", {15'b0, cap_vs[tick]}, 16'h0001);
    RESET = 1'b0;

    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s1);
    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s2);
    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s3);

    for (int h = 0; h < 2; h++) begin
      chk("replay_ox5",    pix(at(s1, h, 5)),   16'h0005);
      chk("replay_ox297",  pix(at(s1, h, 297)), 16'h0129);
      chk("blank_ox298",   pix(at(s1, h, 298)), 16'h1000);
      chk("blank_ox393",   pix(at(s1, h, 393)), 16'h1000);
      chk("hs_ox297_high", {15'b0, cap_hs[at(s1, h, 297)]}, 16'h0001);
      chk("hs_ox298_low",  {15'b0, cap_hs[at(s1, h, 298)]}, 16'h0000);
      chk("hs_ox321_low",  {15'b0, cap_hs[at(s1, h, 321)]}, 16'h0000);
      chk("hs_ox322_high", {15'b0, cap_hs[at(s1, h, 322)]}, 16'h0001);
      chk("vs_active",     {15'b0, cap_vs[at(s1, h, 100)]}, 16'h0001);
    end
    chk("pair2_ox100", pix(at(s2, 1, 100)), 16'h0064);

    // Mid-line reset while a visible pixel is on the output.
    chk("pre_reset_pix", pix(tick), {4'h0, 12'(tick - s3 - 2)});
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_rgb", {4'h0, vid.oRGB}, 16'h0000);
    chk("async_rst_blk", {15'b0, vid.oBLK}, 16'h0001);
    chk("async_rst_hs",  {15'b0, vid.oHSYN}, 16'h0001);
    chk("async_rst_vs",  {15'b0, vid.oVSYN}, 16'h0001);
    idle(3);
    chk("held_rst_pix", pix(tick), 16'h1000);
    chk("held_rst_hs",  {15'b0, cap_hs[tick]}, 16'h0001);
    RESET = 1'b0;

    t = tick;
    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s4);
    chk("len0_blank", pix(t + 40), 16'h1000);
    chk("len0_first", pix(at(s4, 0, 7)), 16'h0007);

    drive_line(HT, 298, 320, 0, 1'b1, 1'b0, s5);
    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s6);
    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s7);
    for (int h = 0; h < 2; h++) begin
      chk("vblk_pix", pix(at(s5, h, 5)), 16'h1000);
      chk("vblk_vs",  {15'b0, cap_vs[at(s5, h, 200)]}, 16'h0000);
    end
    chk("vs_last_low",  {15'b0, cap_vs[s6 + 1]}, 16'h0000);
    chk("vs_edge_high", {15'b0, cap_vs[s6 + 2]}, 16'h0001);
    chk("after_vblk",   pix(at(s6, 0, 5)), 16'h0005);

    drive_line(HT, 298, 320, 1, 1'b0, 1'b1, s8);
    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s9);
    chk("scan_first", pix(at(s8, 0, 10)), 16'h0FFF);
`ifdef RALLYX_SCANDBL_SCANLINES_EN
    chk("scan_second", pix(at(s8, 1, 10)), 16'h0777);
`else
    chk("scan_second", pix(at(s8, 1, 10)), 16'h0FFF);
`endif

    drive_line(700, 600, 640, 0, 1'b0, 1'b1, s10);
    drive_line(HT, 298, 320, 2, 1'b0, 1'b1, s11);
    drive_line(HT, 298, 320, 0, 1'b0, 1'b1, s12);
    chk("ovf_ox5",   pix(at(s10, 0, 5)),   16'h0005);
    chk("ovf_ox300", pix(at(s10, 0, 300)), 16'h012C);
    chk("ovf_ox393", pix(at(s10, 0, 393)), 16'h0189);
    chk("ovf_hs",    {15'b0, cap_hs[at(s10, 0, 300)]}, 16'h0000);
    chk("ovf_h1",    pix(at(s10, 1, 100)), 16'h0064);
    chk("post_ovf_ox5",   pix(at(s11, 0, 5)),   16'h0A05);
    chk("post_ovf_ox297", pix(at(s11, 1, 297)), 16'h0B29);
    chk("post_ovf_ox298", pix(at(s11, 1, 298)), 16'h1000);

    // Input stops: the last line keeps repeating as a second line.
    idle(500);
`ifdef RALLYX_SCANDBL_SCANLINES_EN
    chk("repeat_ox5",   pix(at(s12, 2, 5)),   16'h0002);
    chk("repeat_ox297", pix(at(s12, 2, 297)), 16'h0014);
`else
    chk("repeat_ox5",   pix(at(s12, 2, 5)),   16'h0005);
    chk("repeat_ox297", pix(at(s12, 2, 297)), 16'h0129);
`endif
    chk("repeat_hs", {15'b0, cap_hs[at(s12, 2, 300)]}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
